// File: rtl/lfsr_prng_if.sv
// lfsr_prng_if: word request/delivery handshake between lfsr_prng and its consumer
//   req, word_ready : consumer -> generator
//   word_valid, word: generator -> consumer
interface lfsr_prng_if #(parameter int OUT_BITS = 8);
  logic req;
  logic word_ready;
  logic word_valid;
  logic [OUT_BITS-1:0] word;
  modport master(output req, word_ready, input word_valid, word);
  modport slave(input req, word_ready, output word_valid, word);
endinterface

// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci LFSR, one bit per cycle, OUT_BITS-wide words over valid/ready
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   enable_i        : free-run shift enable (IDLE/DONE)
//   seed_load_i     : load seed_in_i (zero replaced by SEED), aborts any word in progress
//   bus             : req/word_ready in, word_valid/word out
//   busy_o          : FSM in GATHER
//   random_bit_o    : state[0], combinational
//   lfsr_state_o    : current state
//   seed_fix_o      : one-cycle pulse after a zero seed was replaced
//   LFSR_PRNG_DENSITY_EN adds density_i[7:0] and cell_alive_o = state[7:0] < density_i
module lfsr_prng #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int OUT_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  lfsr_prng_if.slave       bus,
  output logic             busy_o,
  output logic             random_bit_o,
  output logic [WIDTH-1:0] lfsr_state_o,
`ifdef LFSR_PRNG_DENSITY_EN
  input  logic [7:0]       density_i,
  output logic             cell_alive_o,
`endif
  output logic             seed_fix_o
);
  localparam int CW = $clog2(OUT_BITS + 1);
  typedef enum logic [1:0] {IDLE, GATHER, DONE} state_t;
  state_t st_q, st_d;
  logic [WIDTH-1:0] state_q, state_d, shifted;
  logic [OUT_BITS-1:0] word_q, word_d, cap;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fb, start, valid_q, busy_q, fix_q, fix_d;
  assign fb = ^(state_q & TAPS);
  assign shifted = {state_q[WIDTH-2:0], fb};
  // truncating the concatenation drops the oldest bit, so the first capture lands in the MSB
  assign cap = OUT_BITS'({word_q, fb});
  always_comb begin
    st_d = st_q;
    state_d = state_q;
    word_d = word_q;
    cnt_d = cnt_q;
    fix_d = 1'b0;
    start = 1'b0;
    if (seed_load_i) begin
      state_d = (seed_in_i == '0) ? SEED : seed_in_i;
      fix_d = (seed_in_i == '0);
      st_d = IDLE;
      cnt_d = '0;
    end else begin
      case (st_q)
        IDLE: begin
          state_d = enable_i ? shifted : state_q;
          start = bus.req;
        end
        GATHER: begin
          state_d = shifted;
          word_d = cap;
          cnt_d = (cnt_q == CW'(OUT_BITS)) ? cnt_q : cnt_q + CW'(1);
          st_d = (cnt_q == CW'(OUT_BITS - 1)) ? DONE : GATHER;
        end
        default: begin
          state_d = enable_i ? shifted : state_q;
          st_d = bus.word_ready ? IDLE : DONE;
          cnt_d = bus.word_ready ? '0 : cnt_q;
          start = bus.word_ready & bus.req;
        end
      endcase
      if (start) begin
        state_d = shifted;
        word_d = cap;
        cnt_d = CW'(1);
        st_d = (OUT_BITS == 1) ? DONE : GATHER;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      state_q <= SEED;
      word_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      fix_q <= 1'b0;
    end else begin
      st_q <= st_d;
      state_q <= state_d;
      word_q <= word_d;
      cnt_q <= cnt_d;
      valid_q <= (st_d == DONE);
      busy_q <= (st_d == GATHER);
      fix_q <= fix_d;
    end
  end
  assign bus.word_valid = valid_q;
  assign bus.word = word_q;
  assign busy_o = busy_q;
  assign random_bit_o = state_q[0];
  assign lfsr_state_o = state_q;
  assign seed_fix_o = fix_q;
`ifdef LFSR_PRNG_DENSITY_EN
  assign cell_alive_o = (state_q[7:0] < density_i);
`endif
endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: self-checking bench for lfsr_prng against an arithmetic LFSR model
module tb_lfsr_prng;
  logic clk = 1'b0;
  logic reset, enable, seed_load, busy, rb, fix;
  logic [15:0] seed_in, st;
  int checks = 0;
  int failures = 0;
  lfsr_prng_if #(.OUT_BITS(8)) bus();
`ifdef LFSR_PRNG_DENSITY_EN
  logic [7:0] density;
  logic alive;
`endif
  lfsr_prng dut (
    .clk(clk), .reset(reset), .enable_i(enable), .seed_load_i(seed_load), .seed_in_i(seed_in),
    .bus(bus), .busy_o(busy), .random_bit_o(rb), .lfsr_state_o(st),
`ifdef LFSR_PRNG_DENSITY_EN
    .density_i(density), .cell_alive_o(alive),
`endif
    .seed_fix_o(fix)
  );
  always #5 clk = ~clk;

  function automatic logic fbit(input logic [15:0] s);
    return logic'($countones(s & 16'hB400) % 2);
  endfunction
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return 16'((32'(s) * 2 + 32'(fbit(s))) % 65536);
  endfunction
  function automatic logic [7:0] pred_word(input logic [15:0] s);
    int w = 0;
    for (int i = 0; i < 8; i++) begin
      w = w * 2 + int'(fbit(s));
      s = nxt(s);
    end
    return 8'(w);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1; enable = 0; seed_load = 0; seed_in = 0; bus.req = 0; bus.word_ready = 0;
`ifdef LFSR_PRNG_DENSITY_EN
    density = 0;
`endif
    tick;
    reset = 0;
  endtask

  task automatic test_reset;
    do_reset;
    checks += 6;
    if (st !== 16'h0001) begin failures++; $display("FAIL reset_state got %h exp 0001", st); end
    if (rb !== 1'b1) begin failures++; $display("FAIL reset_bit got %b exp 1", rb); end
    if (bus.word !== 8'h00) begin failures++; $display("FAIL reset_word got %h exp 00", bus.word); end
    if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", bus.word_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (fix !== 1'b0) begin failures++; $display("FAIL reset_fix got %b exp 0", fix); end
  endtask

  task automatic test_shift_period;
    logic [16:0] m;
    do_reset;
    enable = 1;
    repeat (10) tick;
    checks += 2;
    if (st !== 16'h0400) begin failures++; $display("FAIL shift10_state got %h exp 0400", st); end
    if (rb !== 1'b0) begin failures++; $display("FAIL shift10_bit got %b exp 0", rb); end
    tick;
    checks += 2;
    if (st !== 16'h0801) begin failures++; $display("FAIL shift11_state got %h exp 0801", st); end
    if (rb !== 1'b1) begin failures++; $display("FAIL shift11_bit got %b exp 1", rb); end
    m = {1'b0, st};
    for (int i = 12; i <= 65535; i++) begin
      m = {1'b0, nxt(m[15:0])};
      tick;
      checks++;
      if (st !== m[15:0] || st == 16'h0) begin
        failures++; $display("FAIL period_step%0d got %h exp %h", i, st, m[15:0]);
        break;
      end
    end
    checks++;
    if (st !== 16'h0001) begin failures++; $display("FAIL period_return got %h exp 0001", st); end
    enable = 0;
  endtask

  task automatic test_random_seed_shift;
    logic [15:0] m;
    logic fx;
    do_reset;
    m = 16'h0001;
    for (int i = 0; i < 300; i++) begin
      enable = 1'($urandom);
      seed_load = ($urandom_range(0, 7) == 0);
      seed_in = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      fx = seed_load && seed_in == 16'h0;
      m = seed_load ? (seed_in == 16'h0 ? 16'h0001 : seed_in) : (enable ? nxt(m) : m);
      tick;
      checks += 3;
      if (st !== m) begin failures++; $display("FAIL rand_state cyc%0d got %h exp %h", i, st, m); end
      if (fix !== fx) begin failures++; $display("FAIL rand_fix cyc%0d got %b exp %b", i, fix, fx); end
      if (rb !== m[0]) begin failures++; $display("FAIL rand_bit cyc%0d got %b exp %b", i, rb, m[0]); end
    end
    seed_load = 0; enable = 0;
  endtask

  task automatic test_seed_load;
    do_reset;
    seed_load = 1; seed_in = 16'h0000;
    tick;
    seed_load = 0;
    checks += 2;
    if (st !== 16'h0001) begin failures++; $display("FAIL seed0_state got %h exp 0001", st); end
    if (fix !== 1'b1) begin failures++; $display("FAIL seed0_fix got %b exp 1", fix); end
    tick;
    checks++;
    if (fix !== 1'b0) begin failures++; $display("FAIL seed0_fix_pulse got %b exp 0", fix); end
    seed_load = 1; seed_in = 16'hACE1;
    tick;
    seed_load = 0;
    checks += 2;
    if (st !== 16'hACE1) begin failures++; $display("FAIL seedace1_state got %h exp ace1", st); end
    if (fix !== 1'b0) begin failures++; $display("FAIL seedace1_fix got %b exp 0", fix); end
  endtask

  task automatic test_word(input int pre, input logic [7:0] exp_w, input logic [15:0] exp_s);
    int n, bc;
    logic [15:0] m;
    do_reset;
    enable = 1;
    repeat (pre) tick;
    enable = 0;
    m = st;
    checks++;
    if (pred_word(m) !== exp_w) begin failures++; $display("FAIL word_model got %h exp %h", pred_word(m), exp_w); end
    bus.req = 1;
    tick;
    bus.req = 0;
    n = 1; bc = 0;
    while (bus.word_valid !== 1'b1 && n < 20) begin
      bc += int'(busy === 1'b1);
      tick;
      n++;
    end
    checks += 5;
    if (n !== 8) begin failures++; $display("FAIL word_latency pre%0d got %0d exp 8", pre, n); end
    if (bc !== 7) begin failures++; $display("FAIL word_busy_cycles pre%0d got %0d exp 7", pre, bc); end
    if (bus.word !== exp_w) begin failures++; $display("FAIL word_value pre%0d got %h exp %h", pre, bus.word, exp_w); end
    if (st !== exp_s) begin failures++; $display("FAIL word_state pre%0d got %h exp %h", pre, st, exp_s); end
    if (busy !== 1'b0) begin failures++; $display("FAIL word_busy_done got %b exp 0", busy); end
    enable = 1;
    bus.req = 1;
    repeat (3) tick;
    checks += 2;
    if (bus.word_valid !== 1'b1) begin failures++; $display("FAIL word_hold_valid got %b exp 1", bus.word_valid); end
    if (bus.word !== exp_w) begin failures++; $display("FAIL word_hold_value got %h exp %h", bus.word, exp_w); end
    bus.req = 0; enable = 0; bus.word_ready = 1;
    tick;
    bus.word_ready = 0;
    checks++;
    if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL word_release got %b exp 0", bus.word_valid); end
  endtask

  task automatic test_abort;
    do_reset;
    bus.req = 1;
    tick;
    bus.req = 0;
    repeat (3) tick;
    seed_load = 1; seed_in = 16'h1234; bus.req = 1;
    tick;
    seed_load = 0; bus.req = 0;
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b exp 0", busy); end
    if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got %b exp 0", bus.word_valid); end
    if (st !== 16'h1234) begin failures++; $display("FAIL abort_state got %h exp 1234", st); end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (bus.word_valid !== 1'b0 || st !== 16'h1234) begin
        failures++; $display("FAIL abort_idle cyc%0d got valid=%b state=%h exp valid=0 state=1234", i, bus.word_valid, st);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    logic [7:0] exp_w [5];
    int last, k;
    do_reset;
    seed_in = 16'($urandom_range(1, 65535));
    seed_load = 1;
    tick;
    seed_load = 0;
    s = seed_in;
    for (int j = 0; j < 5; j++) begin
      exp_w[j] = pred_word(s);
      for (int b = 0; b < 8; b++) s = nxt(s);
    end
    bus.req = 1; bus.word_ready = 1; enable = 1'($urandom);
    last = 0; k = 0;
    for (int t = 1; t <= 40; t++) begin
      tick;
      if (bus.word_valid === 1'b1) begin
        checks += 2;
        if (t - last !== 8) begin failures++; $display("FAIL b2b_gap word%0d got %0d exp 8", k, t - last); end
        if (k < 5 && bus.word !== exp_w[k]) begin failures++; $display("FAIL b2b_word%0d got %h exp %h", k, bus.word, exp_w[k]); end
        last = t;
        k++;
      end
    end
    checks += 2;
    if (k !== 5) begin failures++; $display("FAIL b2b_count got %0d exp 5", k); end
    if (st !== s) begin failures++; $display("FAIL b2b_state got %h exp %h", st, s); end
    bus.req = 0; bus.word_ready = 0; enable = 0;
  endtask

`ifdef LFSR_PRNG_DENSITY_EN
  task automatic test_density;
    logic [15:0] m;
    do_reset;
    seed_load = 1; seed_in = 16'h0001;
    tick;
    seed_load = 0;
    density = 8'h02;
    #1;
    checks++;
    if (alive !== 1'b1) begin failures++; $display("FAIL dens02 got %b exp 1", alive); end
    density = 8'h01;
    #1;
    checks++;
    if (alive !== 1'b0) begin failures++; $display("FAIL dens01 got %b exp 0", alive); end
    density = 8'h00;
    enable = 1;
    m = 16'h0001;
    for (int i = 0; i < 1000; i++) begin
      tick;
      m = nxt(m);
      checks++;
      if (alive !== 1'b0) begin failures++; $display("FAIL dens00 cyc%0d got %b exp 0", i, alive); end
    end
    for (int i = 0; i < 200; i++) begin
      density = 8'($urandom);
      tick;
      m = nxt(m);
      checks++;
      if (alive !== (m[7:0] < density)) begin failures++; $display("FAIL dens_rand cyc%0d got %b state %h dens %h", i, alive, st, density); end
    end
    enable = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_shift_period;
    test_random_seed_shift;
    test_seed_load;
    test_word(0, 8'h00, 16'h0100);
    test_word(10, 8'hB4, 16'h00B4);
    test_abort;
    test_back_to_back;
    test_back_to_back;
`ifdef LFSR_PRNG_DENSITY_EN
    test_density;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lfsr_prng.md
# lfsr_prng

Parametrised Fibonacci LFSR pseudo-random generator, successor to the fixed 16-bit single-bit generator. It free-runs one bit per cycle and delivers OUT_BITS-wide random words through a valid/ready handshake. It supports runtime reseeding with zero-seed protection. It feeds the board-initialisation logic of the Conway engine and any other consumer needing random bits or words.

## Interface
- WIDTH, 16: LFSR length in bits; legal range 8..32.
- TAPS, 16'hB400: WIDTH-bit feedback mask. Feedback = XOR-reduce(state & TAPS). Default is maximal-length x^16+x^14+x^13+x^11+1.
- SEED, 1: non-zero state loaded on reset and substituted for a zero seed.
- OUT_BITS, 8: word width; legal range 1..WIDTH.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  free-run shift enable.
- seed_load  in  1  load seed_in into the state this cycle.
- seed_in  in  WIDTH  runtime seed value.
- req  in  1  word request.
- word_ready  in  1  consumer accepts the word.
- word_valid  out  1  word is available.
- word  out  OUT_BITS  random word.
- busy  out  1  high while the FSM is in GATHER.
- random_bit  out  1  state[0].
- lfsr_state  out  WIDTH  current state, for observation and debug.
- seed_fix  out  1  one-cycle pulse when a zero seed was replaced by SEED.

## Operation
- Shift step: state <= {state[WIDTH-2:0], fb}, where fb = ^(state & TAPS). After a shift, random_bit equals the fb that was just computed.
- Priority each cycle: reset > seed_load > shift.
- Seed load:
  - state <= (seed_in == 0) ? SEED : seed_in.
  - seed_fix is high in the following cycle only when seed_in was 0.
  - No shift occurs that cycle.
- The state never holds zero.
- FSM states: IDLE, GATHER, DONE.
- IDLE:
  - Shifts only when enable=1.
  - On req=1, the same edge performs a shift, captures fb as word bit 1 of OUT_BITS, sets cnt=1 and moves to GATHER. If OUT_BITS=1, it moves directly to DONE.
- GATHER:
  - Shifts every cycle regardless of enable.
  - Capture rule: word <= {word[OUT_BITS-2:0], fb}, so the first-captured bit ends in the MSB.
  - After capture number OUT_BITS, moves to DONE.
- DONE:
  - word_valid=1; word is held stable.
  - Shifts only when enable=1; shifting does not alter word.
  - On word_valid & word_ready: if req=1 on that cycle, start a new gather as from IDLE (same-edge capture, back-to-back); otherwise go to IDLE.
- seed_load in GATHER or DONE aborts to IDLE:
  - word_valid drops next cycle.
  - word keeps its last value.
  - A pending req is ignored that cycle.
- req while busy or in DONE without ready: ignored; it is not queued.
- cnt is ceil(log2(OUT_BITS+1)) bits and saturates at OUT_BITS.

## Timing
- Reset values:
  - lfsr_state=SEED, random_bit=SEED[0].
  - word=0, word_valid=0, busy=0, seed_fix=0.
  - FSM=IDLE, cnt=0.
- Word latency: req sampled at edge 0 gives word_valid high after edge OUT_BITS-1, i.e. OUT_BITS cycles. Sustained throughput is one word per OUT_BITS cycles with word_ready held high.
- All outputs are registered except random_bit, which is combinational from the state register.
- Period with maximal TAPS is 2^WIDTH-1 shifts.

## Configuration
- LFSR_PRNG_DENSITY_EN defined:
  - Adds input density[7:0] and output cell_alive = (lfsr_state[7:0] < density), which is combinational.
  - density=0 means never alive; density=0xFF means alive unless the low byte is 0xFF.
- Undefined: both ports are absent and no comparator is built.

## Test plan
- Reset, then enable=1 for 10 cycles: lfsr_state=0x0400, random_bit=0. One more cycle gives 0x0801, random_bit=1. Continue to 65535 total shifts: state returns to 0x0001 and never reaches 0.
- Reset, enable=0, pulse req: word_valid rises 8 cycles later with word=0x00 and lfsr_state=0x0100. busy is high for exactly 7 cycles (cnt 1..7).
- After 10 enable shifts (state 0x0400), pulse req: word=0xB4, lfsr_state=0x00B4, word_valid held until word_ready.
- seed_load with seed_in=0: lfsr_state=0x0001 and seed_fix high for exactly one cycle. seed_in=0xACE1: state=0xACE1 and seed_fix=0.
- seed_load asserted mid-GATHER: FSM returns to IDLE, word_valid never rises, state=seed_in. With req and word_ready held high, word_valid pulses once every 8 cycles with no gap.
- With LFSR_PRNG_DENSITY_EN defined and state 0x0001:
  - density=0x02 gives cell_alive=1.
  - density=0x01 gives cell_alive=0.
  - density=0x00 gives cell_alive=0 over 1000 random cycles.
